// File: rtl/inj_pkg.sv
// Shared types for the fault-injection campaign monitor: FSM states,
// campaign result codes and the window index width.
package inj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_OBSERVE = 2'd2,
        ST_REPORT  = 2'd3
    } state_e;

    localparam logic [1:0] RES_MASKED     = 2'd0;
    localparam logic [1:0] RES_TRANSIENT  = 2'd1;
    localparam logic [1:0] RES_PERSISTENT = 2'd2;

    // WINDOW is at most 255, so an 8-bit index covers 0..WINDOW-1.
    localparam int IDX_W = 8;

endpackage

// File: rtl/inj_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module inj_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/injection_monitor.sv
// Observes a fault-injected copy against its golden twin for WINDOW cycles
// after an injection and classifies the outcome as masked/transient/persistent.
module injection_monitor
    import inj_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             inj_valid,
    input  logic             y1,
    input  logic             y2,
    input  logic             y1_ref,
    input  logic             y2_ref,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic             err_y1,
    output logic             err_y2
);

    localparam logic [IDX_W-1:0] WIN_LAST = IDX_W'(WINDOW - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         result_q, result_d;
    logic [CNT_W-1:0]   first_err_q, first_err_d;
    logic               err_y1_q, err_y1_d;
    logic               err_y2_q, err_y2_d;

    logic m1, m2, mismatch;
    logic take_start, do_abort, observe, win_end, seen_any;

    assign m1         = y1 ^ y1_ref;
    assign m2         = y2 ^ y2_ref;
    assign mismatch   = m1 | m2;
    assign take_start = (state_q == ST_IDLE) && start;
    assign do_abort   = abort && ((state_q == ST_ARMED) || (state_q == ST_OBSERVE));
    assign observe    = (state_q == ST_OBSERVE) && !abort;
    assign win_end    = observe && (idx_q == WIN_LAST);
    // The sticky flags double as "a mismatch has already been seen".
    assign seen_any   = err_y1_q | err_y2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_ARMED;
            ST_ARMED:   if (abort) state_d = ST_IDLE;
                        else if (inj_valid) state_d = ST_OBSERVE;
            ST_OBSERVE: if (abort) state_d = ST_IDLE;
                        else if (idx_q == WIN_LAST) state_d = ST_REPORT;
            ST_REPORT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_REPORT);
    end

    always_comb begin
        idx_d       = (observe && !win_end) ? idx_q + IDX_W'(1) : '0;
        result_d    = result_q;
        first_err_d = first_err_q;
        err_y1_d    = err_y1_q;
        err_y2_d    = err_y2_q;
        if (take_start || do_abort) begin
            result_d    = RES_MASKED;
            first_err_d = '1;
            err_y1_d    = 1'b0;
            err_y2_d    = 1'b0;
        end else if (observe) begin
            if (mismatch) begin
                err_y1_d = err_y1_q | m1;
                err_y2_d = err_y2_q | m2;
                if (!seen_any) first_err_d = CNT_W'(idx_q);
            end
            if (win_end) begin
                if (!(seen_any || mismatch)) result_d = RES_MASKED;
                else if (mismatch)           result_d = RES_PERSISTENT;
                else                         result_d = RES_TRANSIENT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= RES_MASKED;
            first_err_q <= '1;
            err_y1_q    <= 1'b0;
            err_y2_q    <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            first_err_q <= first_err_d;
            err_y1_q    <= err_y1_d;
            err_y2_q    <= err_y2_d;
        end
    end

    inj_sat_counter #(
        .W (CNT_W)
    ) u_mism_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (take_start | do_abort),
        .en_i  (observe & mismatch),
        .cnt_o (mism_cnt)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign first_err = first_err_q;
    assign err_y1    = err_y1_q;
    assign err_y2    = err_y2_q;

endmodule

// File: tb/tb_injection_monitor.sv
// Scoreboard bench: two monitors (CNT_W=8 and CNT_W=2) share stimulus; a
// mask-level reference model predicts each campaign's report.
module tb_injection_monitor;

    localparam int WIN = 16;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0, abort = 1'b0, inj_valid = 1'b0;
    logic y1 = 1'b0, y2 = 1'b0, y1_ref = 1'b0, y2_ref = 1'b0;

    logic       busy, done, err_y1, err_y2;
    logic [1:0] result;
    logic [7:0] mism_cnt, first_err;
    logic       busy_s, done_s, err_y1_s, err_y2_s;
    logic [1:0] result_s, mism_cnt_s, first_err_s;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0] res;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic [7:0] first;
        logic       e1;
        logic       e2;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];

    injection_monitor #(.WINDOW(WIN), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .inj_valid(inj_valid),
        .y1(y1), .y2(y2), .y1_ref(y1_ref), .y2_ref(y2_ref),
        .busy(busy), .done(done), .result(result), .mism_cnt(mism_cnt),
        .first_err(first_err), .err_y1(err_y1), .err_y2(err_y2)
    );

    injection_monitor #(.WINDOW(WIN), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .inj_valid(inj_valid),
        .y1(y1), .y2(y2), .y1_ref(y1_ref), .y2_ref(y2_ref),
        .busy(busy_s), .done(done_s), .result(result_s), .mism_cnt(mism_cnt_s),
        .first_err(first_err_s), .err_y1(err_y1_s), .err_y2(err_y2_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: classify a campaign from per-index mismatch masks.
    function automatic exp_t model(input logic [WIN-1:0] m1, input logic [WIN-1:0] m2);
        exp_t e;
        int   c = 0;
        e.first = 8'hFF;
        for (int i = 0; i < WIN; i++) begin
            if (m1[i] || m2[i]) begin
                if (c == 0) e.first = 8'(i);
                c++;
            end
        end
        e.cnt  = (c > 255) ? 8'd255 : 8'(c);
        e.cnt2 = (c > 3) ? 2'd3 : 2'(c);
        e.e1   = |m1;
        e.e2   = |m2;
        if (c == 0)                       e.res = 2'd0;
        else if (m1[WIN-1] || m2[WIN-1])  e.res = 2'd2;
        else                              e.res = 2'd1;
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic check_report(input string tag, input exp_t e);
        check({tag, "_result"},     32'(result),     32'(e.res));
        check({tag, "_mism_cnt"},   32'(mism_cnt),   32'(e.cnt));
        check({tag, "_first_err"},  32'(first_err),  32'(e.first));
        check({tag, "_err_y1"},     32'(err_y1),     32'(e.e1));
        check({tag, "_err_y2"},     32'(err_y2),     32'(e.e2));
        check({tag, "_sat_result"}, 32'(result_s),   32'(e.res));
        check({tag, "_sat_cnt"},    32'(mism_cnt_s), 32'(e.cnt2));
        check({tag, "_sat_err_y1"}, 32'(err_y1_s),   32'(e.e1));
        check({tag, "_sat_err_y2"}, 32'(err_y2_s),   32'(e.e2));
    endtask

    task automatic check_idle_clear(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_mism_cnt"},  32'(mism_cnt),  32'd0);
        check({tag, "_first_err"}, 32'(first_err), 32'hFF);
        check({tag, "_err_y1"},    32'(err_y1),    32'd0);
        check({tag, "_err_y2"},    32'(err_y2),    32'd0);
        check({tag, "_sat_cnt"},   32'(mism_cnt_s), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (rstn && (done || done_s)) begin
            check("done_pair", 32'(done_s), 32'(done));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("busy_at_done", 32'(busy), 32'd1);
                check_report("mon", e);
            end
        end
    end

    // mode 0: normal, mode 1: abort at stop_idx, mode 2: reset at stop_idx.
    task automatic run_campaign(input logic [WIN-1:0] m1, input logic [WIN-1:0] m2,
                                input int mode, input int stop_idx, input bit noise);
        exp_t e;
        e = model(m1, m2);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat ($urandom_range(2, 0)) begin
            start = noise ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        inj_valid = 1'b1;
        if (mode == 0) begin
            e.done_cyc = cyc + 1 + WIN;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        inj_valid = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            y1_ref = 1'($urandom);
            y2_ref = 1'($urandom);
            y1 = y1_ref ^ m1[i];
            y2 = y2_ref ^ m2[i];
            if (noise) begin
                start     = 1'($urandom);
                inj_valid = 1'($urandom);
            end
            if (mode == 1 && i == stop_idx) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; start = 1'b0; inj_valid = 1'b0;
                check_idle_clear("abort");
                return;
            end
            if (mode == 2 && i == stop_idx) begin
                #2 rstn = 1'b0;
                #1 check_idle_clear("async_reset");
                @(negedge clk);
                start = 1'b0; inj_valid = 1'b0;
                rstn = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; inj_valid = 1'b0;
        y1 = y1_ref; y2 = y2_ref;
        repeat (3) @(posedge clk);
        #1 check_report("hold", e);
    endtask

    initial begin
        logic [WIN-1:0] a, b;
        #2 rstn = 1'b0;
        #2 check_idle_clear("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1 check_idle_clear("post_reset");

        // Fully masked, transient on y1 3..5, persistent on y2 10..15, all-mismatch saturation.
        run_campaign(16'h0000, 16'h0000, 0, 0, 1'b0);
        run_campaign(16'h0038, 16'h0000, 0, 0, 1'b0);
        run_campaign(16'h0000, 16'hFC00, 0, 0, 1'b0);
        run_campaign(16'hFFFF, 16'hFFFF, 0, 0, 1'b0);
        run_campaign(16'h0001, 16'h0000, 0, 0, 1'b0);
        run_campaign(16'h0000, 16'h8000, 0, 0, 1'b0);

        // Abort mid-window after mismatches, then a normal campaign must still run.
        run_campaign(16'h001E, 16'h0004, 1, 7, 1'b0);
        run_campaign(16'h0100, 16'h0000, 0, 0, 1'b0);

        // Reset mid-campaign discards it; start+inj_valid together only arms.
        run_campaign(16'h000F, 16'h0003, 2, 5, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; inj_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; inj_valid = 1'b0;
        check("arm_state", 32'(dut.state_q), 32'(inj_pkg::ST_ARMED));
        check("arm_busy", 32'(busy), 32'd1);
        repeat (WIN + 4) @(posedge clk);
        #1 check("arm_still_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("arm_abort_busy", 32'(busy), 32'd0);

        // Abort in IDLE has no effect on a following campaign's report.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        run_campaign(16'h0C00, 16'h0040, 0, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            case (k % 4)
                0: begin a = 16'($urandom) & 16'($urandom) & 16'($urandom); b = '0; end
                1: begin a = '0; b = 16'($urandom) & 16'($urandom); end
                2: begin a = 16'($urandom); b = 16'($urandom); end
                default: begin a = 16'($urandom) & 16'h7FFF & 16'($urandom); b = 16'($urandom) & 16'h00FF; end
            endcase
            run_campaign(a, b, 0, 0, 1'b1);
        end

        for (int t = 0; t < 64 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d outstanding reports expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/injection_monitor.md
INJECTION_MONITOR -- requirements
Module: injection_monitor

Interface
REQ-001 Parameter WINDOW, default 16: observation window length in cycles; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of mism_cnt and first_err.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to arm a campaign.
REQ-006 abort  input  1  synchronous cancel of the current campaign.
REQ-007 inj_valid  input  1  one-cycle pulse marking the fault injection into the faulty copy.
REQ-008 y1, y2  input  1 each  outputs of the fault-injected injection_module instance.
REQ-009 y1_ref, y2_ref  input  1 each  outputs of the golden (fault-free) instance.
REQ-010 busy  output  1  high in ARMED, OBSERVE and REPORT.
REQ-011 done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
REQ-012 result  output  2  campaign class: 0 MASKED, 1 TRANSIENT, 2 PERSISTENT; 3 is never driven.
REQ-013 mism_cnt  output  CNT_W  number of mismatching window cycles, saturating.
REQ-014 first_err  output  CNT_W  window index of the first mismatch; all-ones if none.
REQ-015 err_y1, err_y2  output  1 each  sticky flags, set if that output mismatched at any point in the window.

Function
REQ-016 FSM states: IDLE, ARMED, OBSERVE, REPORT; all outputs are registered.
REQ-017 IDLE -> ARMED on start; this clears mism_cnt, err_y1, err_y2 and result to 0, and sets first_err to all-ones.
REQ-018 ARMED -> OBSERVE on inj_valid; the window index is 0 in the first OBSERVE cycle.
REQ-019 start and inj_valid asserted together in IDLE: start is taken and inj_valid is ignored; the FSM stays in ARMED.
REQ-020 In each OBSERVE cycle: m1 = y1 xor y1_ref, m2 = y2 xor y2_ref, mismatch = m1 or m2.
REQ-021 On a mismatch cycle: mism_cnt increments and saturates at 2^CNT_W-1.
REQ-022 On a mismatch cycle: err_y1 and err_y2 latch m1 and m2 respectively.
REQ-023 On the first mismatch only: first_err loads the current window index.
REQ-024 OBSERVE lasts exactly WINDOW cycles (index 0..WINDOW-1), then the FSM moves to REPORT.
REQ-025 result, registered on entry to REPORT: MASKED if the final mism_cnt is 0; otherwise PERSISTENT if window index WINDOW-1 mismatched; otherwise TRANSIENT.
REQ-026 REPORT lasts one cycle with done=1, then returns to IDLE.
REQ-027 result, mism_cnt, first_err, err_y1 and err_y2 hold their values until the next accepted start.
REQ-028 start while busy is ignored; inj_valid outside ARMED is ignored.
REQ-029 abort in ARMED or OBSERVE returns to IDLE next cycle: no done pulse, result forced to 0, counters and flags cleared.
REQ-030 abort has priority over inj_valid and over the window-end transition; abort in IDLE or REPORT has no effect.
REQ-031 Latency: done rises exactly WINDOW+1 cycles after the inj_valid edge is sampled.

Reset
REQ-032 rstn low asynchronously forces: state IDLE, busy 0, done 0, result 0, mism_cnt 0, first_err all-ones, err_y1 0, err_y2 0, window index 0.
REQ-033 Reset asserted mid-campaign discards the campaign; no done pulse occurs after reset is released.
REQ-034 Deassertion of rstn is assumed synchronised externally; the block adds no reset synchroniser.

Structure
REQ-035 Shared package inj_pkg holds the FSM state enum and the result codes (RES_MASKED, RES_TRANSIENT, RES_PERSISTENT).
REQ-036 The saturating counter is the single sub-module inj_sat_counter (clear, enable, width parameter); it is instantiated for mism_cnt.
REQ-037 The window index counter stays inline.
REQ-038 The golden and faulty injection_module instances live in the enclosing bench, not in this block.

Verification
REQ-039 WINDOW=16; start, then inj_valid; y=y_ref throughout -> done 17 cycles after inj_valid, result 0, mism_cnt 0, first_err 0xFF, flags 0.
REQ-040 y1 differs at indices 3..5 only -> result 1, mism_cnt 3, first_err 3, err_y1 1, err_y2 0.
REQ-041 y2 differs from index 10 through 15 -> result 2, mism_cnt 6, first_err 10, err_y2 1.
REQ-042 CNT_W=2, all 16 cycles mismatch on both outputs -> mism_cnt 3 (saturated), result 2, both flags 1.
REQ-043 abort at index 7 after mismatches -> no done pulse, busy low next cycle, result 0, mism_cnt 0; a following start is accepted normally.
REQ-044 rstn pulsed low at index 5 -> all outputs at reset values immediately; start and inj_valid in the same IDLE cycle -> state ARMED, not OBSERVE.
